// File: rtl/snake_dir_input.sv
// Snake game direction input: synchronises and debounces four buttons, turns
// presses into turn requests, filters them and applies one queued turn per game step.
module snake_dir_input #(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         QUEUE_DEPTH     = 2,
  parameter logic [3:0] INIT_DIR        = 4'b0010,
  parameter bit         ALLOW_REVERSE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       l,
  input  logic       r,
  input  logic       u,
  input  logic       d,
  input  logic       step,
  output logic [3:0] direction,
  output logic [3:0] pressed,
  output logic       turn_pending,
  output logic       queue_full
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NW = 3;

  logic [3:0]    w_raw;
  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [3:0]    r_pressed;
  logic [3:0]    r_pressed_d;
  logic [CW-1:0] r_cnt [4];

  logic [3:0]    r_q [QUEUE_DEPTH];
  logic [NW-1:0] r_count;
  logic [3:0]    r_dir;
  logic          r_turn_pending;
  logic          r_queue_full;

  logic [3:0]    w_rise;
  logic [3:0]    w_cand;
  logic [3:0]    w_ref;
  logic [3:0]    w_opp;
  logic          w_pop;
  logic          w_push;
  logic [NW-1:0] w_wr_idx;
  logic [NW-1:0] w_count_next;
  logic [3:0]    w_q_next [QUEUE_DEPTH];

  assign w_raw = {d, u, r, l};

  // The counter holds DEBOUNCE_CYCLES for one cycle before the flip, so the
  // level must differ for DEBOUNCE_CYCLES+1 synchronised samples in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_pressed   <= '0;
      r_pressed_d <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_s1        <= w_raw;
      r_s2        <= r_s1;
      r_pressed_d <= r_pressed;
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] == r_pressed[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
          r_pressed[i] <= r_s2[i];
          r_cnt[i]     <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    w_rise = r_pressed & ~r_pressed_d;
    w_cand = '0;
    if (w_rise[2])      w_cand = 4'b0100;
    else if (w_rise[3]) w_cand = 4'b1000;
    else if (w_rise[0]) w_cand = 4'b0001;
    else if (w_rise[1]) w_cand = 4'b0010;
  end

  // Reference is the newest queued turn, falling back to the live direction.
  always_comb begin
    w_ref = r_dir;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (r_count == NW'(i + 1)) w_ref = r_q[i];
    end
    w_opp = {w_ref[2], w_ref[3], w_ref[0], w_ref[1]};
  end

  assign w_pop    = step && (r_count != '0);
  assign w_push   = (w_cand != '0) && (w_cand != w_ref) &&
                    (ALLOW_REVERSE || (w_cand != w_opp)) &&
                    ((r_count != NW'(QUEUE_DEPTH)) || w_pop);
  assign w_wr_idx = w_pop ? (r_count - NW'(1)) : r_count;
  assign w_count_next = r_count + NW'(w_push) - NW'(w_pop);

  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) w_q_next[i] = r_q[i];
    if (w_pop) begin
      for (int i = 0; i < QUEUE_DEPTH - 1; i++) w_q_next[i] = r_q[i + 1];
    end
    if (w_push) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (NW'(i) == w_wr_idx) w_q_next[i] = w_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir          <= INIT_DIR;
      r_count        <= '0;
      r_turn_pending <= 1'b0;
      r_queue_full   <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) r_q[i] <= w_q_next[i];
      r_count        <= w_count_next;
      r_turn_pending <= (w_count_next != '0);
      r_queue_full   <= (w_count_next == NW'(QUEUE_DEPTH));
      if (w_pop) r_dir <= r_q[0];
    end
  end

  assign direction    = r_dir;
  assign pressed      = r_pressed;
  assign turn_pending = r_turn_pending;
  assign queue_full   = r_queue_full;

endmodule

// File: tb/tb_snake_dir_input.sv
// Bench for snake_dir_input: two instances (reverse blocked / allowed) driven by
// directed and random button traffic and compared every cycle to a turn-list model.
module tb_snake_dir_input;

  localparam int         DB   = 4;
  localparam int         QD   = 2;
  localparam logic [3:0] INIT = 4'b0010;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       step;
  logic [3:0] dir0, prs0, dir1, prs1;
  logic       tp0, qf0, tp1, qf1;

  int n_chk = 0;
  int n_err = 0;

  // model state: debounced levels, raw sample history, per-instance turn lists
  logic [3:0] m_p, m_pd;
  logic [3:0] m_dir [2];
  logic [3:0] m_qa  [2][4];
  int         m_qn  [2];
  logic [3:0] hist  [$];

  always #5 clk = ~clk;

  snake_dir_input #(.DEBOUNCE_CYCLES(DB), .QUEUE_DEPTH(QD), .INIT_DIR(INIT), .ALLOW_REVERSE(1'b0)) dut (
    .clk(clk), .rst(rst), .l(btn[0]), .r(btn[1]), .u(btn[2]), .d(btn[3]), .step(step),
    .direction(dir0), .pressed(prs0), .turn_pending(tp0), .queue_full(qf0)
  );

  snake_dir_input #(.DEBOUNCE_CYCLES(DB), .QUEUE_DEPTH(QD), .INIT_DIR(INIT), .ALLOW_REVERSE(1'b1)) dut_rev (
    .clk(clk), .rst(rst), .l(btn[0]), .r(btn[1]), .u(btn[2]), .d(btn[3]), .step(step),
    .direction(dir1), .pressed(prs1), .turn_pending(tp1), .queue_full(qf1)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] opposite(input logic [3:0] x);
    case (x)
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0001;
      4'b0100: return 4'b1000;
      4'b1000: return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_p  = '0;
    m_pd = '0;
    for (int k = 0; k < 2; k++) begin
      m_dir[k] = INIT;
      m_qn[k]  = 0;
    end
    hist.delete();
    for (int i = 0; i < DB + 3; i++) hist.push_back(4'b0000);
  endtask

  // One clock edge of the reference: turn handling from the previous debounced
  // levels, then a debounced level flips once DB+1 consecutive raw samples,
  // ending two edges back, all disagree with it.
  task automatic model_edge();
    logic [3:0] rise, cand, refd, newp;
    bit         popq, acc, all_diff;
    if (rst) begin
      model_reset();
      return;
    end
    rise = m_p & ~m_pd;
    cand = '0;
    if (rise[2])      cand = 4'b0100;
    else if (rise[3]) cand = 4'b1000;
    else if (rise[0]) cand = 4'b0001;
    else if (rise[1]) cand = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      refd = (m_qn[k] > 0) ? m_qa[k][m_qn[k] - 1] : m_dir[k];
      popq = step && (m_qn[k] > 0);
      acc  = (cand != 0) && (cand != refd) && ((k == 1) || (cand != opposite(refd))) &&
             ((m_qn[k] < QD) || popq);
      if (popq) begin
        m_dir[k] = m_qa[k][0];
        for (int i = 0; i < 3; i++) m_qa[k][i] = m_qa[k][i + 1];
        m_qn[k]--;
      end
      if (acc) begin
        m_qa[k][m_qn[k]] = cand;
        m_qn[k]++;
      end
    end
    hist.push_back(btn);
    if (hist.size() > DB + 3) void'(hist.pop_front());
    newp = m_p;
    for (int ch = 0; ch < 4; ch++) begin
      all_diff = 1'b1;
      for (int i = 0; i <= DB; i++) if (hist[i][ch] == m_p[ch]) all_diff = 1'b0;
      if (all_diff) newp[ch] = ~m_p[ch];
    end
    m_pd = m_p;
    m_p  = newp;
  endtask

  task automatic check_all();
    chk("dir0", dir0, m_dir[0]);
    chk("prs0", prs0, m_p);
    chk("tp0",  {3'b000, tp0}, {3'b000, m_qn[0] != 0});
    chk("qf0",  {3'b000, qf0}, {3'b000, m_qn[0] == QD});
    chk("dir1", dir1, m_dir[1]);
    chk("prs1", prs1, m_p);
    chk("tp1",  {3'b000, tp1}, {3'b000, m_qn[1] != 0});
    chk("qf1",  {3'b000, qf1}, {3'b000, m_qn[1] == QD});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Reset is raised mid-cycle and checked before any clock edge arrives.
  task automatic do_reset();
    step = 1'b0;
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_dir0", dir0, INIT);
    chk("rst_prs0", prs0, 4'b0000);
    chk("rst_tp0",  {3'b000, tp0}, 4'b0000);
    chk("rst_qf0",  {3'b000, qf0}, 4'b0000);
    check_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] b, input int hold, input int rel);
    btn = b;
    repeat (hold) tick();
    btn = '0;
    repeat (rel) tick();
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    btn  = '0;
    step = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // clean press of up, with the exact debounce and queue latency
    do_reset();
    btn = 4'b0100;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (e == 5) chk("clean_p_e5", prs0, 4'b0000);
      if (e == 6) chk("clean_p_e6", prs0, 4'b0100);
      if (e == 6) chk("clean_tp_e6", {3'b000, tp0}, 4'b0000);
      if (e == 7) chk("clean_tp_e7", {3'b000, tp0}, 4'b0001);
    end
    btn = '0;
    repeat (8) tick();
    do_step();
    chk("clean_dir", dir0, 4'b0100);
    chk("clean_tp_after", {3'b000, tp0}, 4'b0000);

    // glitch shorter than the debounce window
    do_reset();
    press(4'b0001, 3, 10);
    chk("glitch_p", prs0, 4'b0000);
    chk("glitch_tp", {3'b000, tp0}, 4'b0000);
    chk("glitch_dir", dir0, 4'b0010);

    // reverse and duplicate rejection; reverse allowed on the second instance
    do_reset();
    press(4'b0001, 8, 8);
    chk("rev_tp0", {3'b000, tp0}, 4'b0000);
    chk("rev_tp1", {3'b000, tp1}, 4'b0001);
    do_step();
    chk("rev_dir0", dir0, 4'b0010);
    chk("rev_dir1", dir1, 4'b0001);
    press(4'b0010, 8, 8);
    chk("dup_tp0", {3'b000, tp0}, 4'b0000);

    // queue fills, a third turn is dropped, then drains in order
    do_reset();
    press(4'b0100, 8, 8);
    press(4'b0001, 8, 8);
    chk("q_full", {3'b000, qf0}, 4'b0001);
    press(4'b1000, 8, 8);
    chk("q_full_drop", {3'b000, qf0}, 4'b0001);
    do_step();
    chk("q_dir_a", dir0, 4'b0100);
    do_step();
    chk("q_dir_b", dir0, 4'b0001);
    chk("q_tp_empty", {3'b000, tp0}, 4'b0000);

    // all four buttons together: only up survives arbitration
    do_reset();
    press(4'b1111, 8, 8);
    chk("all_tp", {3'b000, tp0}, 4'b0001);
    chk("all_qf", {3'b000, qf0}, 4'b0000);
    do_step();
    chk("all_dir", dir0, 4'b0100);

    // reset with two turns queued discards them
    do_reset();
    press(4'b0100, 8, 8);
    press(4'b0001, 8, 8);
    do_reset();
    repeat (3) begin
      do_step();
      tick();
    end
    chk("rstq_dir", dir0, 4'b0010);
    chk("rstq_tp", {3'b000, tp0}, 4'b0000);

    // random traffic: glitches, overlaps, random steps and occasional resets
    for (int seg = 0; seg < 250; seg++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 14)      btn = 4'(1 << $urandom_range(0, 3));
      else if (sel < 17) btn = 4'($urandom_range(0, 15));
      else               btn = '0;
      if ($urandom_range(0, 49) == 0) do_reset();
      repeat ($urandom_range(1, 10)) begin
        step = ($urandom_range(0, 5) == 0);
        tick();
      end
      step = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
